rs_scheduler: RTL and testbench

- Reservation station plus issue scheduler for the integer ALU.
- Accepts decoded non-memory instructions from the decoder (rs_en path) and holds them until both operands are known.
- Snoops ALU/LSB result broadcasts to wake waiting operands.
- Each cycle selects one ready entry and dispatches it to the ALU through a registered output stage.

---
 rtl/rs_scheduler_pkg.sv | 56 +++++
 rtl/rs_priority_pick.sv | 25 ++
 rtl/rs_scheduler.sv | 159 +++++++++++++++
 tb/tb_rs_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_scheduler_pkg.sv
// Shared widths, tag encoding and entry layout for the ALU reservation station.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
package rs_scheduler_pkg;

    localparam int ROB_POS_WID  = 4;
    localparam int ROB_ID_WID   = 5;
    localparam int DATA_WID     = 32;
    localparam int ADDR_WID     = 32;
    localparam int OPCODE_WID   = 7;
    localparam int FUNCT3_WID   = 3;
    localparam int TAG_PEND_BIT = 4;   // tag bit set => operand still waiting on a ROB result
    localparam int RS_SIZE_DEF  = 16;

    typedef struct packed {
        logic [ROB_ID_WID-1:0] tag;
        logic [DATA_WID-1:0]   val;
    } opnd_t;

    typedef struct packed {
        logic [OPCODE_WID-1:0]  opcode;
        logic [FUNCT3_WID-1:0]  funct3;
        logic                   funct7;
        opnd_t                  op1;
        opnd_t                  op2;
        logic [DATA_WID-1:0]    imm;
        logic [ADDR_WID-1:0]    pc;
        logic [ROB_POS_WID-1:0] rob_pos;
        logic                   pred_jump;
    } rs_entry_t;

    // Resolve a pending operand against the two result buses; ALU bus wins a tie.
    function automatic opnd_t snoop(
        input opnd_t                  cur,
        input logic                   alu_vld,
        input logic [ROB_POS_WID-1:0] alu_pos,
        input logic [DATA_WID-1:0]    alu_val,
        input logic                   lsb_vld,
        input logic [ROB_POS_WID-1:0] lsb_pos,
        input logic [DATA_WID-1:0]    lsb_val
    );
        opnd_t res;
        res = cur;
        if (cur.tag[TAG_PEND_BIT]) begin
            if (alu_vld && cur.tag[ROB_POS_WID-1:0] == alu_pos) begin
                res.tag = '0;
                res.val = alu_val;
            end else if (lsb_vld && cur.tag[ROB_POS_WID-1:0] == lsb_pos) begin
                res.tag = '0;
                res.val = lsb_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_priority_pick.sv
// Lowest-index set-bit finder over a request vector.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request bit is set.
module rs_priority_pick #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan high to low so the lowest set bit is the last (winning) assignment.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_scheduler.sv
// Integer-ALU reservation station: holds issued ops, snoops result buses, dispatches lowest ready entry.
// Latency: entry ready in registered state at cycle t -> alu_en high in cycle t+1 (registered output).
// Backpressure: rs_nxt_full when count >= RS_SIZE-1; rdy=0 freezes all state and outputs.
module rs_scheduler
    import rs_scheduler_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int RS_IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   rollback,

    input  logic                   rs_en,
    input  logic [ROB_POS_WID-1:0] issue_rob_pos,
    input  logic [OPCODE_WID-1:0]  issue_opcode,
    input  logic [FUNCT3_WID-1:0]  issue_funct3,
    input  logic                   issue_funct7,
    input  logic [DATA_WID-1:0]    issue_rs1_val,
    input  logic [ROB_ID_WID-1:0]  issue_rs1_rob_id,
    input  logic [DATA_WID-1:0]    issue_rs2_val,
    input  logic [ROB_ID_WID-1:0]  issue_rs2_rob_id,
    input  logic [DATA_WID-1:0]    issue_imm,
    input  logic [ADDR_WID-1:0]    issue_pc,
    input  logic                   issue_pred_jump,
    output logic                   rs_nxt_full,

    input  logic                   alu_result,
    input  logic [ROB_POS_WID-1:0] alu_result_rob_pos,
    input  logic [DATA_WID-1:0]    alu_result_val,
    input  logic                   lsb_result,
    input  logic [ROB_POS_WID-1:0] lsb_result_rob_pos,
    input  logic [DATA_WID-1:0]    lsb_result_val,

    output logic                   alu_en,
    output logic [OPCODE_WID-1:0]  alu_opcode,
    output logic [FUNCT3_WID-1:0]  alu_funct3,
    output logic                   alu_funct7,
    output logic [DATA_WID-1:0]    alu_val1,
    output logic [DATA_WID-1:0]    alu_val2,
    output logic [DATA_WID-1:0]    alu_imm,
    output logic [ADDR_WID-1:0]    alu_pc,
    output logic [ROB_POS_WID-1:0] alu_rob_pos,
    output logic                   alu_pred_jump
);

    logic [RS_SIZE-1:0]  valid;
    rs_entry_t           ent [RS_SIZE];
    logic [RS_IDX_W:0]   count;

    logic [RS_SIZE-1:0]  ready_vec;
    logic                free_found;
    logic [RS_IDX_W-1:0] free_idx;
    logic                sel_found;
    logic [RS_IDX_W-1:0] sel_idx;
    logic                issue_ok;
    rs_entry_t           new_ent;

    // Readiness is taken from registered state only, so fresh writes never bypass into select.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = valid[i] & ~ent[i].op1.tag[TAG_PEND_BIT] & ~ent[i].op2.tag[TAG_PEND_BIT];
        end
    end

    // Free slot is chosen before this cycle's dispatch frees anything.
    rs_priority_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_pick (
        .req   (~valid),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_priority_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_pick (
        .req   (ready_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    assign issue_ok    = rs_en & free_found;
    assign rs_nxt_full = (count >= (RS_IDX_W+1)'(RS_SIZE - 1));

    // Incoming entry with its pending operands resolved against this cycle's broadcasts.
    always_comb begin
        new_ent.opcode    = issue_opcode;
        new_ent.funct3    = issue_funct3;
        new_ent.funct7    = issue_funct7;
        new_ent.imm       = issue_imm;
        new_ent.pc        = issue_pc;
        new_ent.rob_pos   = issue_rob_pos;
        new_ent.pred_jump = issue_pred_jump;
        new_ent.op1       = snoop('{tag: issue_rs1_rob_id, val: issue_rs1_val},
                                  alu_result, alu_result_rob_pos, alu_result_val,
                                  lsb_result, lsb_result_rob_pos, lsb_result_val);
        new_ent.op2       = snoop('{tag: issue_rs2_rob_id, val: issue_rs2_val},
                                  alu_result, alu_result_rob_pos, alu_result_val,
                                  lsb_result, lsb_result_rob_pos, lsb_result_val);
    end

    // Entry payload: wake waiting operands and write the newly issued op; no reset needed.
    always_ff @(posedge clk) begin
        if (rst && !rollback && rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid[i]) begin
                    ent[i].op1 <= snoop(ent[i].op1, alu_result, alu_result_rob_pos, alu_result_val,
                                        lsb_result, lsb_result_rob_pos, lsb_result_val);
                    ent[i].op2 <= snoop(ent[i].op2, alu_result, alu_result_rob_pos, alu_result_val,
                                        lsb_result, lsb_result_rob_pos, lsb_result_val);
                end
            end
            if (issue_ok) begin
                ent[free_idx] <= new_ent;
            end
        end
    end

    // Control state and registered dispatch stage: reset > rollback > hold on !rdy > run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid         <= '0;
            count         <= '0;
            alu_en        <= 1'b0;
            alu_opcode    <= '0;
            alu_funct3    <= '0;
            alu_funct7    <= 1'b0;
            alu_val1      <= '0;
            alu_val2      <= '0;
            alu_imm       <= '0;
            alu_pc        <= '0;
            alu_rob_pos   <= '0;
            alu_pred_jump <= 1'b0;
        end else if (rollback) begin
            valid  <= '0;
            count  <= '0;
            alu_en <= 1'b0;
        end else if (rdy) begin
            if (sel_found) begin
                valid[sel_idx] <= 1'b0;
                alu_en         <= 1'b1;
                alu_opcode     <= ent[sel_idx].opcode;
                alu_funct3     <= ent[sel_idx].funct3;
                alu_funct7     <= ent[sel_idx].funct7;
                alu_val1       <= ent[sel_idx].op1.val;
                alu_val2       <= ent[sel_idx].op2.val;
                alu_imm        <= ent[sel_idx].imm;
                alu_pc         <= ent[sel_idx].pc;
                alu_rob_pos    <= ent[sel_idx].rob_pos;
                alu_pred_jump  <= ent[sel_idx].pred_jump;
            end else begin
                alu_en <= 1'b0;
            end
            if (issue_ok) begin
                valid[free_idx] <= 1'b1;
            end
            count <= count + (RS_IDX_W+1)'(issue_ok) - (RS_IDX_W+1)'(sel_found);
        end
    end

endmodule

// File: tb/tb_rs_scheduler.sv
module tb_rs_scheduler;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        rs_en;
    logic [3:0]  issue_rob_pos;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7;
    logic [31:0] issue_rs1_val;
    logic [4:0]  issue_rs1_rob_id;
    logic [31:0] issue_rs2_val;
    logic [4:0]  issue_rs2_rob_id;
    logic [31:0] issue_imm;
    logic [31:0] issue_pc;
    logic        issue_pred_jump;
    logic        rs_nxt_full;
    logic        alu_result;
    logic [3:0]  alu_result_rob_pos;
    logic [31:0] alu_result_val;
    logic        lsb_result;
    logic [3:0]  lsb_result_rob_pos;
    logic [31:0] lsb_result_val;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;
    logic        alu_pred_jump;

    int checks;
    int errors;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    rs_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .rollback           (rollback),
        .rs_en              (rs_en),
        .issue_rob_pos      (issue_rob_pos),
        .issue_opcode       (issue_opcode),
        .issue_funct3       (issue_funct3),
        .issue_funct7       (issue_funct7),
        .issue_rs1_val      (issue_rs1_val),
        .issue_rs1_rob_id   (issue_rs1_rob_id),
        .issue_rs2_val      (issue_rs2_val),
        .issue_rs2_rob_id   (issue_rs2_rob_id),
        .issue_imm          (issue_imm),
        .issue_pc           (issue_pc),
        .issue_pred_jump    (issue_pred_jump),
        .rs_nxt_full        (rs_nxt_full),
        .alu_result         (alu_result),
        .alu_result_rob_pos (alu_result_rob_pos),
        .alu_result_val     (alu_result_val),
        .lsb_result         (lsb_result),
        .lsb_result_rob_pos (lsb_result_rob_pos),
        .lsb_result_val     (lsb_result_val),
        .alu_en             (alu_en),
        .alu_opcode         (alu_opcode),
        .alu_funct3         (alu_funct3),
        .alu_funct7         (alu_funct7),
        .alu_val1           (alu_val1),
        .alu_val2           (alu_val2),
        .alu_imm            (alu_imm),
        .alu_pc             (alu_pc),
        .alu_rob_pos        (alu_rob_pos),
        .alu_pred_jump      (alu_pred_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    // Also guards the protocol: no issue into a completely full station.
    task automatic step();
        if (rst && rdy && !rollback && rs_en && dut.count == 5'd16) begin
            errors++;
            $display("FAIL proto_issue_when_full: count=%0d rs_en=1 required no issue", dut.count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rdy                = 1'b1;
        rollback           = 1'b0;
        rs_en              = 1'b0;
        issue_rob_pos      = '0;
        issue_opcode       = '0;
        issue_funct3       = '0;
        issue_funct7       = 1'b0;
        issue_rs1_val      = '0;
        issue_rs1_rob_id   = '0;
        issue_rs2_val      = '0;
        issue_rs2_rob_id   = '0;
        issue_imm          = '0;
        issue_pc           = '0;
        issue_pred_jump    = 1'b0;
        alu_result         = 1'b0;
        alu_result_rob_pos = '0;
        alu_result_val     = '0;
        lsb_result         = 1'b0;
        lsb_result_rob_pos = '0;
        lsb_result_val     = '0;
    endtask

    task automatic drive_issue(input logic [3:0] pos, input logic [6:0] opc,
                               input logic [31:0] v1, input logic [4:0] t1,
                               input logic [31:0] v2, input logic [4:0] t2,
                               input logic [31:0] imm, input logic [31:0] pc);
        rs_en            = 1'b1;
        issue_rob_pos    = pos;
        issue_opcode     = opc;
        issue_funct3     = 3'd0;
        issue_funct7     = 1'b0;
        issue_rs1_val    = v1;
        issue_rs1_rob_id = t1;
        issue_rs2_val    = v2;
        issue_rs2_rob_id = t2;
        issue_imm        = imm;
        issue_pc         = pc;
        issue_pred_jump  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL reset_alu_en: got %b want 0", alu_en); end
        checks++; if (rs_nxt_full !== 1'b0) begin errors++; $display("FAIL reset_nxt_full: got %b want 0", rs_nxt_full); end
        checks++; if (alu_val1 !== 32'd0 || alu_rob_pos !== 4'd0 || alu_opcode !== 7'd0) begin
            errors++; $display("FAIL reset_alu_fields: val1=%h rob=%h opc=%h want all 0", alu_val1, alu_rob_pos, alu_opcode);
        end
        checks++; if (dut.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.count); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_addi();
        drive_issue(4'd3, OP_ADDI, 32'd5, 5'h00, 32'd0, 5'h00, 32'd7, 32'h1000);
        step();
        clear_inputs();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL addi_early: alu_en=%b want 0", alu_en); end
        step();
        checks++; if (alu_en !== 1'b1 || alu_val1 !== 32'd5 || alu_imm !== 32'd7 || alu_rob_pos !== 4'd3 || alu_opcode !== OP_ADDI || alu_pc !== 32'h1000) begin
            errors++; $display("FAIL addi_dispatch: en=%b val1=%h imm=%h rob=%h opc=%h pc=%h want 1/5/7/3/13/1000", alu_en, alu_val1, alu_imm, alu_rob_pos, alu_opcode, alu_pc);
        end
        step();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL addi_drop: alu_en=%b want 0", alu_en); end
    endtask

    task automatic test_wakeup_alu();
        drive_issue(4'd4, OP_ADD, 32'd0, 5'h12, 32'h22, 5'h00, 32'd0, 32'h2000);
        step();
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL wake_wait%0d: alu_en=%b want 0", c, alu_en); end
            step();
        end
        alu_result         = 1'b1;
        alu_result_rob_pos = 4'd2;
        alu_result_val     = 32'h100;
        step();
        clear_inputs();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL wake_same_cycle: alu_en=%b want 0", alu_en); end
        step();
        checks++; if (alu_en !== 1'b1 || alu_val1 !== 32'h100 || alu_val2 !== 32'h22 || alu_rob_pos !== 4'd4) begin
            errors++; $display("FAIL wake_dispatch: en=%b val1=%h val2=%h rob=%h want 1/100/22/4", alu_en, alu_val1, alu_val2, alu_rob_pos);
        end
        step();
    endtask

    task automatic test_issue_snoop();
        drive_issue(4'd5, OP_ADD, 32'd9, 5'h00, 32'd0, 5'h17, 32'd0, 32'h3000);
        lsb_result         = 1'b1;
        lsb_result_rob_pos = 4'd7;
        lsb_result_val     = 32'hABC;
        step();
        clear_inputs();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL snoop_no_bypass: alu_en=%b want 0", alu_en); end
        step();
        checks++; if (alu_en !== 1'b1 || alu_val2 !== 32'hABC || alu_val1 !== 32'd9 || alu_rob_pos !== 4'd5) begin
            errors++; $display("FAIL snoop_dispatch: en=%b val1=%h val2=%h rob=%h want 1/9/abc/5", alu_en, alu_val1, alu_val2, alu_rob_pos);
        end
        step();
    endtask

    task automatic test_full();
        for (int k = 0; k < 15; k++) begin
            drive_issue(4'(k), OP_ADD, 32'd0, (k == 0) ? 5'h10 : 5'h1F, 32'd1, 5'h00, 32'd0, 32'h4000 + 32'(k));
            step();
            if (k == 13) begin
                checks++; if (rs_nxt_full !== 1'b0) begin errors++; $display("FAIL full_at14: rs_nxt_full=%b want 0", rs_nxt_full); end
            end
        end
        clear_inputs();
        checks++; if (rs_nxt_full !== 1'b1 || dut.count !== 5'd15) begin
            errors++; $display("FAIL full_at15: rs_nxt_full=%b count=%0d want 1/15", rs_nxt_full, dut.count);
        end
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL full_no_dispatch: alu_en=%b want 0", alu_en); end
        alu_result         = 1'b1;
        alu_result_rob_pos = 4'd0;
        alu_result_val     = 32'h55;
        step();
        clear_inputs();
        checks++; if (alu_en !== 1'b0 || rs_nxt_full !== 1'b1) begin errors++; $display("FAIL full_wake: alu_en=%b full=%b want 0/1", alu_en, rs_nxt_full); end
        step();
        checks++; if (alu_en !== 1'b1 || alu_rob_pos !== 4'd0 || alu_val1 !== 32'h55 || dut.count !== 5'd14 || rs_nxt_full !== 1'b0) begin
            errors++; $display("FAIL full_drain: en=%b rob=%h val1=%h count=%0d full=%b want 1/0/55/14/0", alu_en, alu_rob_pos, alu_val1, dut.count, rs_nxt_full);
        end
        rollback = 1'b1;
        step();
        clear_inputs();
        checks++; if (dut.count !== 5'd0 || alu_en !== 1'b0) begin errors++; $display("FAIL full_flush: count=%0d en=%b want 0/0", dut.count, alu_en); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            drive_issue(4'(10 + k), OP_ADD, 32'd0, 5'h14, 32'(k), 5'h00, 32'd0, 32'h5000);
            step();
        end
        clear_inputs();
        alu_result         = 1'b1;
        alu_result_rob_pos = 4'd4;
        alu_result_val     = 32'h77;
        step();
        clear_inputs();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL b2b_wait: alu_en=%b want 0", alu_en); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (alu_en !== 1'b1 || alu_rob_pos !== 4'(10 + k) || alu_val2 !== 32'(k) || alu_val1 !== 32'h77) begin
                errors++; $display("FAIL b2b_order%0d: en=%b rob=%0d val2=%h val1=%h want 1/%0d/%h/77", k, alu_en, alu_rob_pos, alu_val2, alu_val1, 10 + k, k);
            end
        end
        step();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL b2b_end: alu_en=%b want 0", alu_en); end
    endtask

    task automatic test_rollback();
        for (int k = 0; k < 6; k++) begin
            drive_issue(4'(k), OP_ADD, 32'd0, 5'h19, 32'd0, 5'h00, 32'd0, 32'h6000);
            step();
        end
        clear_inputs();
        alu_result         = 1'b1;
        alu_result_rob_pos = 4'd9;
        alu_result_val     = 32'h9;
        step();
        clear_inputs();
        step();
        checks++; if (alu_en !== 1'b1 || alu_rob_pos !== 4'd0 || dut.count !== 5'd5) begin
            errors++; $display("FAIL rb_pre: en=%b rob=%0d count=%0d want 1/0/5", alu_en, alu_rob_pos, dut.count);
        end
        rollback = 1'b1;
        drive_issue(4'd8, OP_ADDI, 32'd1, 5'h00, 32'd0, 5'h00, 32'd0, 32'h6100);
        step();
        clear_inputs();
        checks++; if (alu_en !== 1'b0 || dut.count !== 5'd0 || rs_nxt_full !== 1'b0) begin
            errors++; $display("FAIL rb_flush: en=%b count=%0d full=%b want 0/0/0", alu_en, dut.count, rs_nxt_full);
        end
        step();
        step();
        checks++; if (alu_en !== 1'b0) begin errors++; $display("FAIL rb_ignored_issue: alu_en=%b want 0", alu_en); end
    endtask

    task automatic test_rdy_freeze();
        for (int k = 0; k < 3; k++) begin
            drive_issue(4'(1 + k), OP_ADD, 32'd0, 5'h16, 32'd0, 5'h00, 32'(100 + k), 32'h7000);
            step();
        end
        clear_inputs();
        alu_result         = 1'b1;
        alu_result_rob_pos = 4'd6;
        alu_result_val     = 32'h66;
        step();
        clear_inputs();
        step();
        checks++; if (alu_en !== 1'b1 || alu_rob_pos !== 4'd1 || dut.count !== 5'd2) begin
            errors++; $display("FAIL rdy_pre: en=%b rob=%0d count=%0d want 1/1/2", alu_en, alu_rob_pos, dut.count);
        end
        rdy = 1'b0;
        drive_issue(4'd9, OP_ADDI, 32'd1, 5'h00, 32'd0, 5'h00, 32'd0, 32'h7100);
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (alu_en !== 1'b1 || alu_rob_pos !== 4'd1 || alu_imm !== 32'd100 || dut.count !== 5'd2) begin
                errors++; $display("FAIL rdy_frozen%0d: en=%b rob=%0d imm=%0d count=%0d want 1/1/100/2", c, alu_en, alu_rob_pos, alu_imm, dut.count);
            end
        end
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (alu_en !== 1'b1 || alu_rob_pos !== 4'(2 + k) || alu_imm !== 32'(101 + k) || alu_val1 !== 32'h66) begin
                errors++; $display("FAIL rdy_resume%0d: en=%b rob=%0d imm=%0d val1=%h want 1/%0d/%0d/66", k, alu_en, alu_rob_pos, alu_imm, alu_val1, 2 + k, 101 + k);
            end
        end
        step();
        checks++; if (alu_en !== 1'b0 || dut.count !== 5'd0) begin
            errors++; $display("FAIL rdy_end: en=%b count=%0d want 0/0", alu_en, dut.count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        clear_inputs();
        test_reset();
        test_addi();
        test_wakeup_alu();
        test_issue_snoop();
        test_full();
        test_back_to_back();
        test_rollback();
        test_rdy_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
